// File: rtl/exu_div_mbpta_sched.sv
// exu_div_mbpta_sched: shares one divider between two issue pipes,
// answering a fixed LATENCY cycles after acceptance.
module exu_div_mbpta_sched #(
  parameter int unsigned LATENCY  = 34,
  parameter int unsigned PRIO_RST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_dividend,
  input  logic [63:0] req_divisor,
  input  logic [1:0]  req_sign,
  input  logic [1:0]  req_rem,
  input  logic [1:0]  req_flush,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_sign,
  output logic        div_rem,
  output logic        div_cancel,
  input  logic        div_finish,
  input  logic [31:0] div_out,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP
  } state_e;

  localparam logic [5:0] LAT_M1  = 6'(LATENCY - 1);
  localparam logic [5:0] LAT_SAT = 6'(LATENCY);
  localparam logic       PRIO0   = 1'(PRIO_RST);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        prio_q;
  logic        owner_q;
  logic        start_q;
  logic        cancel_q;
  logic        canc_q;
  logic        seen_q;
  logic        terr_q;
  logic        sign_q;
  logic        rem_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [31:0] res_q;
  logic [31:0] rdat_q;

  logic [1:0]  elig;
  logic        win;
  logic        idle;
  logic        resp;
  logic        acc;
  logic        oflush;
  logic        kill;
  logic        fire;
  logic        tmo;
  logic [31:0] rsp_c;

  assign elig   = req_valid & ~req_flush;
  assign win    = (elig == 2'b11) ? prio_q : elig[1];
  assign idle   = (state_q == S_IDLE);
  assign resp   = (state_q == S_RESP);
  assign acc    = idle & (|elig);
  assign oflush = ~idle & req_flush[owner_q];
  // a flush landing in the response cycle still suppresses it
  assign kill   = canc_q | (resp & req_flush[owner_q]);
  assign fire   = resp & ~kill;
  assign tmo    = resp & ~seen_q & ~div_finish & ~kill;
  // late finish in the response cycle is forwarded directly
  assign rsp_c  = seen_q ? res_q :
                  (div_finish ? div_out : 32'd0);

  assign req_ready    = (rst | ~acc) ? 2'b00 :
                        (win ? 2'b10 : 2'b01);
  assign rsp_valid    = (rst | ~fire) ? 2'b00 :
                        (owner_q ? 2'b10 : 2'b01);
  assign rsp_data     = rst ? 32'd0 : (fire ? rsp_c : rdat_q);
  assign div_start    = ~rst & start_q;
  assign div_cancel   = ~rst & cancel_q;
  assign div_dividend = rst ? 32'd0 : dvd_q;
  assign div_divisor  = rst ? 32'd0 : dvs_q;
  assign div_sign     = ~rst & sign_q;
  assign div_rem      = ~rst & rem_q;
  assign busy         = ~rst & ~idle;
  assign owner        = rst ? PRIO0 : owner_q;
  assign timeout_err  = ~rst & terr_q;

  // FSM, operand/result capture, cancel sequencing and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      prio_q   <= PRIO0;
      owner_q  <= PRIO0;
      start_q  <= 1'b0;
      cancel_q <= 1'b0;
      canc_q   <= 1'b0;
      seen_q   <= 1'b0;
      terr_q   <= 1'b0;
      sign_q   <= 1'b0;
      rem_q    <= 1'b0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      res_q    <= 32'd0;
      rdat_q   <= 32'd0;
    end else begin
      start_q  <= 1'b0;
      cancel_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            state_q <= S_RUN;
            cnt_q   <= 6'd1;
            owner_q <= win;
            prio_q  <= ~win;
            start_q <= 1'b1;
            canc_q  <= 1'b0;
            seen_q  <= 1'b0;
            dvd_q   <= win ? req_dividend[63:32] : req_dividend[31:0];
            dvs_q   <= win ? req_divisor[63:32] : req_divisor[31:0];
            sign_q  <= req_sign[win];
            rem_q   <= req_rem[win];
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAT_M1) begin
            state_q <= S_RESP;
            cnt_q   <= LAT_SAT;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          cnt_q   <= 6'd0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 6'd0;
        end
      endcase
      if (oflush) begin
        canc_q <= 1'b1;
        if (~canc_q & ~seen_q & ~div_finish)
          cancel_q <= 1'b1;
      end
      if (~idle & div_finish & ~seen_q) begin
        seen_q <= 1'b1;
        res_q  <= div_out;
      end
      if (fire)
        rdat_q <= rsp_c;
      if (tmo)
        terr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exu_div_mbpta_sched.sv
// tb_exu_div_mbpta_sched: directed stimulus with a response
// scoreboard and a behavioural divider.
module tb_exu_div_mbpta_sched;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_dividend;
  logic [63:0] req_divisor;
  logic [1:0]  req_sign;
  logic [1:0]  req_rem;
  logic [1:0]  req_flush;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_sign;
  logic        div_rem;
  logic        div_cancel;
  logic        div_finish = 1'b0;
  logic [31:0] div_out = 32'd0;
  logic        busy;
  logic        owner;
  logic        timeout_err;

  exu_div_mbpta_sched #(
    .LATENCY(LAT),
    .PRIO_RST(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .req_sign(req_sign),
    .req_rem(req_rem),
    .req_flush(req_flush),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .div_start(div_start),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_sign(div_sign),
    .div_rem(div_rem),
    .div_cancel(div_cancel),
    .div_finish(div_finish),
    .div_out(div_out),
    .busy(busy),
    .owner(owner),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_t = -1000;
  int   exp_cancel = -1;
  int   fin_delay = 7;
  bit   pend = 1'b0;
  int   fin_cyc = 0;
  logic [31:0] mres = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dmodel(
    input logic [31:0] a, input logic [31:0] b,
    input logic s, input logic r);
    if (s)
      return r ? 32'($signed(a) % $signed(b)) :
                 32'($signed(a) / $signed(b));
    return r ? (a % b) : (a / b);
  endfunction

  // behavioural divider: finishes fin_delay cycles after start
  always @(negedge clk) begin
    if (rst || div_cancel) begin
      pend = 1'b0;
    end else if (div_start) begin
      pend = 1'b1;
      fin_cyc = cyc + fin_delay;
      mres = dmodel(div_dividend, div_divisor, div_sign, div_rem);
    end
  end

  always @(posedge clk) begin
    #1;
    div_finish = 1'b0;
    if (pend && cyc == fin_cyc) begin
      div_finish = 1'b1;
      div_out = mres;
    end
  end

  // monitor: response scoreboard plus occupancy/pulse checks
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      chk("rsp_missing_cyc", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_cyc", cyc, e.cyc);
        chk("rsp_idx", rsp_valid, (e.idx != 0) ? 32'd2 : 32'd1);
        chk("rsp_data", rsp_data, e.data);
      end
    end
    if (rst) begin
      last_t = -1000;
    end else begin
      if (cyc > last_t && cyc <= last_t + LAT) begin
        chk("ready_busy", req_ready, 32'd0);
        chk("busy_run", busy, 32'd1);
      end
      if (cyc == last_t + LAT + 1)
        chk("busy_end", busy, 32'd0);
      if (div_start || cyc == last_t + 1)
        chk("div_start", div_start, (cyc == last_t + 1) ? 1 : 0);
      if (div_cancel || cyc == exp_cancel)
        chk("div_cancel", div_cancel, (cyc == exp_cancel) ? 1 : 0);
      if ((req_valid & req_ready) != 2'b00)
        last_t = cyc;
    end
  end

  task automatic set_ops(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         input logic r);
    if (i == 0) begin
      req_dividend[31:0] = a;
      req_divisor[31:0]  = b;
    end else begin
      req_dividend[63:32] = a;
      req_divisor[63:32]  = b;
    end
    req_sign[i] = s;
    req_rem[i]  = r;
  endtask

  task automatic wait_acc(output logic [1:0] acc, output int t);
    acc = 2'b00;
    t = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!rst && (req_valid & req_ready) != 2'b00) begin
        acc = req_valid & req_ready;
        t = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL acc_timeout: no grant within 100 cycles");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0)
        return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL idle_timeout: busy=%0d pending=%0d",
             busy, sb.size());
  endtask

  task automatic run_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic s,
                        input logic r, input logic [31:0] e);
    logic [1:0] acc;
    int t;
    @(posedge clk);
    #1;
    set_ops(i, a, b, s, r);
    req_valid[i] = 1'b1;
    wait_acc(acc, t);
    chk("op_grant", acc, (i != 0) ? 32'd2 : 32'd1);
    if (t >= 0)
      sb.push_back('{cyc: t + LAT, idx: i, data: e});
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("owner", owner, i);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] acc;
    int t;
    int t2;
    int prev;
    rst = 1'b1;
    req_valid = 2'b11;
    req_flush = 2'b00;
    req_sign = 2'b00;
    req_rem = 2'b00;
    req_dividend = 64'd0;
    req_divisor = 64'd0;
    set_ops(0, 32'd100, 32'd7, 1'b0, 1'b0);
    set_ops(1, 32'd100, 32'd7, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_div_start", div_start, 32'd0);
    chk("rst_terr", timeout_err, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_owner", owner, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round robin with both requesters always valid
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_acc(acc, t);
      chk("arb_idx", acc, (k % 2 != 0) ? 32'd2 : 32'd1);
      if (k > 0)
        chk("arb_gap", t - prev, 32'd35);
      if (t >= 0)
        sb.push_back('{cyc: t + LAT, idx: k % 2,
                       data: (k % 2 != 0) ? 32'd2 : 32'd14});
      prev = t;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();
    chk("terr_clean", timeout_err, 32'd0);

    // finish time must not move the response
    fin_delay = 7;
    run_op(0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
    chk("rsp_hold", rsp_data, 32'd14);
    fin_delay = 1;
    run_op(0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
    fin_delay = 32;
    run_op(0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
    fin_delay = 33;
    run_op(1, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
    chk("terr_late_fin", timeout_err, 32'd0);
    fin_delay = 7;
    run_op(1, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2);
    run_op(0, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 32'hFFFFFFF2);
    run_op(1, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE);

    // flush in the acceptance cycle hands the grant to the other side
    @(posedge clk);
    #1;
    set_ops(0, 32'd100, 32'd7, 1'b0, 1'b0);
    set_ops(1, 32'd200, 32'd9, 1'b0, 1'b0);
    req_valid = 2'b11;
    req_flush = 2'b01;
    wait_acc(acc, t);
    chk("flush_acc_idx", acc, 32'd2);
    if (t >= 0)
      sb.push_back('{cyc: t + LAT, idx: 1, data: 32'd22});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_flush = 2'b00;
    wait_idle();

    // owner flush: cancel pulse, no response, full occupancy
    fin_delay = 20;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b1;
    wait_acc(acc, t);
    chk("fl_grant", acc, 32'd2);
    exp_cancel = t + 6;
    do begin
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
    end while (cyc < t + 5);
    req_flush[1] = 1'b1;
    @(posedge clk);
    #1;
    req_flush[1] = 1'b0;
    req_valid[0] = 1'b1;
    wait_acc(acc, t2);
    chk("fl_next_idx", acc, 32'd1);
    chk("fl_next_cyc", t2, t + 35);
    if (t2 >= 0)
      sb.push_back('{cyc: t2 + LAT, idx: 0, data: 32'd14});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();

    // divider never answers
    fin_delay = 1000;
    run_op(0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    chk("terr_set", timeout_err, 32'd1);
    repeat (3) @(negedge clk);
    chk("terr_sticky", timeout_err, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("terr_rst", timeout_err, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("terr_clear", timeout_err, 32'd0);

    // reset in the middle of an operation
    fin_delay = 7;
    @(posedge clk);
    #1;
    set_ops(0, 32'd100, 32'd7, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    wait_acc(acc, t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t + 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_cancel", div_cancel, 32'd0);
    chk("mid_rst_ready", req_ready, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_acc(acc, t2);
    chk("mid_rst_reacc", t2, t + 6);
    chk("mid_rst_idle", busy, 32'd0);
    if (t2 >= 0)
      sb.push_back('{cyc: t2 + LAT, idx: 0, data: 32'd14});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
